ecall_controller: RTL and testbench

//  Sequences ECALL instructions between the core pipeline, the register file's ECALL write port and board I/O.

---
 rtl/ecall_controller.sv | 111 +++++++++++
 tb/tb_ecall_controller.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ecall_controller.sv
// ecall_controller: stalls the pipeline for an ECALL and runs the print, read or exit service.
// A confirm-button handshake gates each service, and read results are written back to x10.
module ecall_controller #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SW_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ecall_valid,
  input  logic [31:0]         a0_data,
  input  logic [31:0]         a7_data,
  input  logic [SW_WIDTH-1:0] sw_in,
  input  logic                confirm_btn,
  output logic                stall,
  output logic                halt,
  output logic                EcallWrite,
  output logic [31:0]         EcallResult,
  output logic [31:0]         disp_data,
  output logic                disp_valid,
  output logic                led_waiting
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, WAIT_PRESS, WAIT_RELEASE, WRITEBACK, DONE, HALT} state_t;
  state_t r_state, w_next;
  logic r_sync1, r_sync2, r_db, r_db_prev, r_armed;
  logic [CW-1:0] r_cnt, r_low_cnt;
  logic [31:0] r_svc, r_disp, r_result;
  logic w_press, w_valid_svc, w_accept;
  assign w_valid_svc = (a7_data == 32'd1) || (a7_data == 32'd5) || (a7_data == 32'd12) || (a7_data == 32'd10);
  assign w_accept = (r_state == IDLE) && ecall_valid && w_valid_svc;
  assign w_press = r_db && !r_db_prev && r_armed;
  assign disp_data = r_disp;
  // Arming needs a full debounce window of released samples, so the reset values in the
  // synchroniser cannot arm the button when it is held through reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_db <= 1'b0;
      r_db_prev <= 1'b0;
      r_armed <= 1'b0;
      r_cnt <= '0;
      r_low_cnt <= '0;
    end else begin
      r_sync1 <= confirm_btn;
      r_sync2 <= r_sync1;
      r_db_prev <= r_db;
      if (r_sync2 == r_db) r_cnt <= '0;
      else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        r_cnt <= '0;
        r_db <= r_sync2;
      end else r_cnt <= r_cnt + 1'b1;
      r_low_cnt <= r_sync2 ? '0 : (r_low_cnt == CW'(DEBOUNCE_CYCLES) ? r_low_cnt : r_low_cnt + 1'b1);
      if (!r_db && r_low_cnt == CW'(DEBOUNCE_CYCLES)) r_armed <= 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_svc <= '0;
      r_disp <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_svc <= a7_data;
        r_disp <= a0_data;
      end
      if (r_state == WAIT_PRESS && w_press)
        r_result <= (r_svc == 32'd12) ? {24'b0, sw_in[7:0]} : {{(32-SW_WIDTH){sw_in[SW_WIDTH-1]}}, sw_in};
    end
  end
  always_comb begin
    w_next = r_state;
    stall = 1'b0;
    halt = 1'b0;
    EcallWrite = 1'b0;
    EcallResult = '0;
    disp_valid = 1'b0;
    led_waiting = 1'b0;
    case (r_state)
      IDLE: begin
        stall = w_accept;
        if (w_accept) w_next = (a7_data == 32'd10) ? HALT : WAIT_PRESS;
      end
      WAIT_PRESS: begin
        stall = 1'b1;
        led_waiting = 1'b1;
        disp_valid = (r_svc == 32'd1);
        if (w_press) w_next = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        stall = 1'b1;
        disp_valid = (r_svc == 32'd1);
        if (!r_db) w_next = (r_svc == 32'd5 || r_svc == 32'd12) ? WRITEBACK : DONE;
      end
      WRITEBACK: begin
        stall = 1'b1;
        EcallWrite = 1'b1;
        EcallResult = r_result;
        w_next = DONE;
      end
      DONE: w_next = IDLE;
      HALT: begin
        stall = 1'b1;
        halt = 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_ecall_controller.sv
// tb_ecall_controller: directed ECALL scenarios; expected x10 writes are queued by the
// stimulus and checked by an independent monitor whenever EcallWrite is seen.
module tb_ecall_controller;
  logic clk = 1'b0, rst = 1'b1, ecall_valid = 1'b0, confirm_btn = 1'b0;
  logic [31:0] a0_data = '0, a7_data = '0;
  logic [15:0] sw_in = '0;
  logic stall, halt, EcallWrite, disp_valid, led_waiting;
  logic [31:0] EcallResult, disp_data;
  int n_checks = 0, n_fail = 0, n_writes = 0, w0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;
  ecall_controller dut (
    .clk(clk), .rst(rst), .ecall_valid(ecall_valid), .a0_data(a0_data), .a7_data(a7_data),
    .sw_in(sw_in), .confirm_btn(confirm_btn), .stall(stall), .halt(halt), .EcallWrite(EcallWrite),
    .EcallResult(EcallResult), .disp_data(disp_data), .disp_valid(disp_valid), .led_waiting(led_waiting)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (EcallWrite === 1'b1) begin
      n_checks++;
      n_writes++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got result %h, required no write", EcallResult);
      end else begin
        mon_exp = exp_q.pop_front();
        if (EcallResult !== mon_exp) begin
          n_fail++;
          $display("FAIL ecall_result: got %h required %h", EcallResult, mon_exp);
        end
      end
    end
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic start(input logic [31:0] a7, input logic [31:0] a0, input logic exp_stall);
    ecall_valid = 1'b1;
    a7_data = a7;
    a0_data = a0;
    #1;
    check("stall_on_accept", {31'b0, stall}, {31'b0, exp_stall});
    @(posedge clk);
    #1;
    ecall_valid = 1'b0;
  endtask
  task automatic wait_done(input string name);
    logic got = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!stall) begin
        got = 1'b1;
        break;
      end
    end
    check({name, "_done"}, {31'b0, got}, 32'd1);
    check({name, "_no_write_at_done"}, {31'b0, EcallWrite}, 32'd0);
    tick();
  endtask
  task automatic outputs_zero(input string name);
    @(negedge clk);
    check({name, "_flags"}, {26'b0, stall, halt, EcallWrite, disp_valid, led_waiting}, 32'd0);
    check({name, "_disp"}, disp_data, 32'd0);
    check({name, "_result"}, EcallResult, 32'd0);
  endtask
  initial begin
    logic got;
    repeat (3) tick();
    outputs_zero("reset");
    tick();
    rst = 1'b0;
    repeat (10) tick();
    // print int
    w0 = n_writes;
    start(32'd1, 32'hDEAD_BEEF, 1'b1);
    @(negedge clk);
    check("print_disp_data", disp_data, 32'hDEAD_BEEF);
    check("print_disp_valid", {31'b0, disp_valid}, 32'd1);
    check("print_led", {31'b0, led_waiting}, 32'd1);
    tick();
    confirm_btn = 1'b1;
    repeat (12) tick();
    confirm_btn = 1'b0;
    wait_done("print");
    check("print_writes", n_writes - w0, 32'd0);
    repeat (10) tick();
    // read int
    w0 = n_writes;
    sw_in = 16'h8005;
    exp_q.push_back(32'hFFFF_8005);
    start(32'd5, 32'd0, 1'b1);
    confirm_btn = 1'b1;
    repeat (12) tick();
    confirm_btn = 1'b0;
    wait_done("read_int");
    check("read_int_writes", n_writes - w0, 32'd1);
    repeat (10) tick();
    // read char, switches change after the press
    w0 = n_writes;
    sw_in = 16'h12C3;
    exp_q.push_back(32'h0000_00C3);
    start(32'd12, 32'd0, 1'b1);
    confirm_btn = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (!led_waiting) begin
        got = 1'b1;
        break;
      end
    end
    check("read_char_press_seen", {31'b0, got}, 32'd1);
    tick();
    sw_in = 16'h0001;
    repeat (6) tick();
    confirm_btn = 1'b0;
    wait_done("read_char");
    check("read_char_writes", n_writes - w0, 32'd1);
    repeat (10) tick();
    // bouncing button yields a single capture
    w0 = n_writes;
    sw_in = 16'h0042;
    exp_q.push_back(32'h0000_0042);
    start(32'd5, 32'd0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      confirm_btn = ~confirm_btn;
      tick();
    end
    confirm_btn = 1'b1;
    repeat (12) tick();
    confirm_btn = 1'b0;
    wait_done("bounce");
    check("bounce_writes", n_writes - w0, 32'd1);
    repeat (10) tick();
    // reset mid-service aborts with no write
    w0 = n_writes;
    sw_in = 16'h1111;
    start(32'd5, 32'd0, 1'b1);
    @(negedge clk);
    check("abort_led_before_reset", {31'b0, led_waiting}, 32'd1);
    tick();
    rst = 1'b1;
    outputs_zero("abort_reset");
    tick();
    rst = 1'b0;
    repeat (10) tick();
    check("abort_writes", n_writes - w0, 32'd0);
    // button held through reset gives no press until released and pressed again
    confirm_btn = 1'b1;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (10) tick();
    w0 = n_writes;
    sw_in = 16'h0007;
    exp_q.push_back(32'h0000_0007);
    start(32'd5, 32'd0, 1'b1);
    repeat (10) tick();
    @(negedge clk);
    check("held_no_press", {31'b0, led_waiting}, 32'd1);
    tick();
    confirm_btn = 1'b0;
    repeat (12) tick();
    @(negedge clk);
    check("held_release_no_press", {31'b0, led_waiting}, 32'd1);
    tick();
    confirm_btn = 1'b1;
    repeat (12) tick();
    confirm_btn = 1'b0;
    wait_done("held");
    check("held_writes", n_writes - w0, 32'd1);
    repeat (10) tick();
    // unknown service is a no-op
    start(32'd7, 32'd0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("unknown_idle", {30'b0, stall, led_waiting}, 32'd0);
    end
    tick();
    // exit halts until reset
    start(32'd10, 32'd0, 1'b1);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      check("exit_halt_stall", {30'b0, halt, stall}, 32'd3);
    end
    #1;
    rst = 1'b1;
    #1;
    check("exit_cleared_by_reset", {30'b0, halt, stall}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
